// File: rtl/systolic_array_ctrl.sv
// N x N output-stationary systolic matmul (C = A*B) with internal input skew and row-wise result readout.
// Results appear K+2N cycles after start with no input bubbles; array holds on empty beats, out_data holds while out_ready is low.
module systolic_array_ctrl #(
    parameter int N         = 4,
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter int KW        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [KW-1:0]            k_len,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*OP_WIDTH-1:0]    a_col,
    input  logic [N*OP_WIDTH-1:0]    b_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*ACC_WIDTH-1:0]   out_data,
    output logic                     out_last,
    output logic                     done
);

    localparam int FW = $clog2(2 * N);
    localparam int RW = $clog2(N);
    localparam int PW = 2 * OP_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, OUT} state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k_lat, k_cnt;
    logic [FW-1:0]   f_cnt;
    logic [RW-1:0]   row;

    logic accept, beat, step, row_hs, last_beat, flush_end, last_row;

    logic signed [OP_WIDTH-1:0]  a_inj [N];
    logic signed [OP_WIDTH-1:0]  b_inj [N];
    logic signed [OP_WIDTH-1:0]  a_sk  [N];
    logic signed [OP_WIDTH-1:0]  b_sk  [N];
    logic signed [OP_WIDTH-1:0]  a_reg [N][N];
    logic signed [OP_WIDTH-1:0]  b_reg [N][N];
    logic signed [PW-1:0]        prod  [N][N];
    logic signed [ACC_WIDTH-1:0] acc   [N][N];

    assign accept    = (state == IDLE) && start;
    assign beat      = in_valid && in_ready;
    assign step      = ((state == LOAD) && in_valid) || (state == FLUSH);
    assign row_hs    = out_valid && out_ready;
    assign last_beat = beat && (k_cnt == (k_lat - KW'(1)));
    assign flush_end = (f_cnt == FW'(2 * N - 2));
    assign last_row  = (row == RW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        in_ready  = (state == LOAD);
        out_valid = (state == OUT);
        out_last  = (state == OUT) && last_row;
        case (state)
            IDLE:    if (start) state_nxt = (k_len != '0) ? LOAD : FLUSH;
            LOAD:    if (last_beat) state_nxt = FLUSH;
            FLUSH:   if (flush_end) state_nxt = OUT;
            OUT:     if (row_hs && last_row) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_lat <= '0;
            k_cnt <= '0;
            f_cnt <= '0;
            row   <= '0;
            done  <= 1'b0;
        end else begin
            done <= row_hs && last_row;
            if (accept) begin
                k_lat <= k_len;
                k_cnt <= '0;
                f_cnt <= '0;
                row   <= '0;
            end
            if (beat) k_cnt <= k_cnt + KW'(1);
            if (state == FLUSH) f_cnt <= f_cnt + FW'(1);
            if (row_hs) row <= last_row ? '0 : row + RW'(1);
        end
    end

    // Zeros are injected at the array edge once the host stream has ended.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_inj[i] = (state == LOAD) ? a_col[i*OP_WIDTH +: OP_WIDTH] : '0;
            b_inj[i] = (state == LOAD) ? b_row[i*OP_WIDTH +: OP_WIDTH] : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_sk[0] = a_inj[0];
            assign b_sk[0] = b_inj[0];
        end else begin : g_line
            logic signed [OP_WIDTH-1:0] a_line [i];
            logic signed [OP_WIDTH-1:0] b_line [i];
            always_ff @(posedge clk) begin
                if (reset || accept) begin
                    for (int s = 0; s < i; s++) begin
                        a_line[s] <= '0;
                        b_line[s] <= '0;
                    end
                end else if (step) begin
                    a_line[0] <= a_inj[i];
                    b_line[0] <= b_inj[i];
                    for (int s = 1; s < i; s++) begin
                        a_line[s] <= a_line[s-1];
                        b_line[s] <= b_line[s-1];
                    end
                end
            end
            assign a_sk[i] = a_line[i-1];
            assign b_sk[i] = b_line[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod[i][j] = PW'(a_reg[i][j]) * PW'(b_reg[i][j]);
            end
        end
    end

    // Accumulators use the operands latched on the previous step, so each PE sees A and B of the same k.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end
            end
        end else if (step) begin
            for (int i = 0; i < N; i++) begin
                a_reg[i][0] <= a_sk[i];
                b_reg[0][i] <= b_sk[i];
                for (int j = 1; j < N; j++) begin
                    a_reg[i][j] <= a_reg[i][j-1];
                    b_reg[j][i] <= b_reg[j-1][i];
                end
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= acc[i][j] + ACC_WIDTH'(prod[i][j]);
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < N; j++) begin
            out_data[j*ACC_WIDTH +: ACC_WIDTH] = out_valid ? acc[row][j] : '0;
        end
    end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl at N=2, 16-bit accumulators: multiply, signed wrap, bubbles/stall, back-to-back, k_len=0, reset mid-job.
module tb_systolic_array_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] k_len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_col;
    logic [15:0] b_row;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        done;

    int errs   = 0;
    int checks = 0;
    int am [2][8];
    int bm [8][2];
    int cm [2][2];

    systolic_array_ctrl #(.N(2), .OP_WIDTH(8), .ACC_WIDTH(16), .KW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_col     (a_col),
        .b_row     (b_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_in_ready"},  in_ready,  0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"},  out_last,  0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_out_data"},  out_data,  0);
    endtask

    task automatic set_basic();
        am[0][0] = 1; am[0][1] = 2; am[1][0] = 3; am[1][1] = 4;
        bm[0][0] = 5; bm[0][1] = 6; bm[1][0] = 7; bm[1][1] = 8;
        cm[0][0] = 19; cm[0][1] = 22; cm[1][0] = 43; cm[1][1] = 50;
    endtask

    // Starts in the current cycle, streams K beats, reads both rows; returns in the done cycle.
    task automatic run_job(input string name, input int k, input bit toggle, input int stall);
        int  edges;
        int  bi;
        int  bubbles;
        bit  saw_ready;
        chk({name, "_idle_in_ready"}, in_ready, 0);
        start = 1'b1;
        k_len = 16'(k);
        tick();
        start = 1'b0;
        edges = 1; bi = 0; bubbles = 0; saw_ready = 0;
        while (!out_valid && edges < 300) begin
            in_valid = 1'b0;
            if (in_ready && bi < 8) begin
                saw_ready = 1;
                in_valid  = toggle ? edges[0] : 1'b1;
                if (!in_valid) bubbles++;
                for (int i = 0; i < 2; i++) begin
                    a_col[i*8 +: 8] = am[i][bi][7:0];
                    b_row[i*8 +: 8] = bm[bi][i][7:0];
                end
            end
            tick();
            if (in_valid) bi++;
            in_valid = 1'b0;
            edges++;
        end
        chk({name, "_out_valid"}, out_valid, 1);
        chk({name, "_latency"}, edges, k + 4 + bubbles);
        chk({name, "_beats"}, bi, k);
        chk({name, "_in_ready_seen"}, saw_ready, k != 0);
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                for (int s = 0; s < stall; s++) begin
                    out_ready = 1'b0;
                    chk({name, "_stall_valid"}, out_valid, 1);
                    chk({name, "_stall_d0"}, out_data[15:0],  cm[0][0] & 'hFFFF);
                    chk({name, "_stall_d1"}, out_data[31:16], cm[0][1] & 'hFFFF);
                    chk({name, "_stall_last"}, out_last, 0);
                    tick();
                end
            end
            out_ready = 1'b1;
            chk({name, "_row_valid"}, out_valid, 1);
            chk({name, "_c", 8'(48 + r), "0"}, out_data[15:0],  cm[r][0] & 'hFFFF);
            chk({name, "_c", 8'(48 + r), "1"}, out_data[31:16], cm[r][1] & 'hFFFF);
            chk({name, "_last"}, out_last, r == 1);
            chk({name, "_no_early_done"}, done, 0);
            tick();
            out_ready = 1'b0;
        end
        chk({name, "_done"}, done, 1);
        chk({name, "_busy_in_done"}, busy, 0);
        chk({name, "_out_valid_cleared"}, out_valid, 0);
    endtask

    task automatic idle_after(input string name);
        tick();
        chk({name, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        int seen_done;
        int seen_valid;
        reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_col = '0; b_row = '0; out_ready = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("rst_held");
        reset = 1'b0;
        tick();
        chk_reset_outputs("rst");

        set_basic();
        run_job("basic", 2, 0, 0);
        idle_after("basic");

        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) begin
                am[i][k] = 127; bm[k][i] = 127;
            end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) cm[i][j] = 'hFC04;
        run_job("pos_wrap", 4, 0, 0);
        idle_after("pos_wrap");

        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) am[i][k] = -128;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) cm[i][j] = 'h0200;
        run_job("neg_wrap", 4, 0, 0);
        idle_after("neg_wrap");

        set_basic();
        run_job("bubble", 2, 1, 3);

        am[0][0] = 1; am[0][1] = 0; am[1][0] = 0; am[1][1] = 1;
        bm[0][0] = -3; bm[0][1] = 9; bm[1][0] = 100; bm[1][1] = -128;
        cm[0][0] = -3; cm[0][1] = 9; cm[1][0] = 100; cm[1][1] = -128;
        run_job("b2b", 2, 0, 0);
        idle_after("b2b");

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) cm[i][j] = 0;
        run_job("k0", 0, 0, 0);
        idle_after("k0");

        set_basic();
        start = 1'b1; k_len = 16'd2;
        tick();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            chk("rmid_in_ready", in_ready, 1);
            in_valid = 1'b1;
            for (int i = 0; i < 2; i++) begin
                a_col[i*8 +: 8] = am[i][b][7:0];
                b_row[i*8 +: 8] = bm[b][i][7:0];
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("rmid_flush_busy", busy, 1);
        chk("rmid_flush_no_ready", in_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_outputs("rmid");
        seen_done = 0; seen_valid = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) seen_done++;
            if (out_valid || busy) seen_valid++;
        end
        chk("rmid_no_done", seen_done, 0);
        chk("rmid_stays_idle", seen_valid, 0);
        run_job("fresh", 2, 0, 0);
        idle_after("fresh");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule
